// File: rtl/shreg_pkg.sv
// Shared mode encodings and count-width helper for the parametrised shift register.
package shreg_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Bits needed to hold 0..depth inclusive.
   function automatic int calc_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/shreg_stage.sv
// One WIDTH-bit shift-register stage with a hold/left/right/load next-value mux.
module shreg_stage
   import shreg_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] lower,
   input  logic [WIDTH-1:0] upper,
   input  logic [WIDTH-1:0] load,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;

   // Only the selected source reaches the register, so X on unused inputs stays out.
   always_comb begin
      q_next = q_reg;
      if (en) begin
         case (mode)
            MODE_SHL:  q_next = lower;
            MODE_SHR:  q_next = upper;
            MODE_LOAD: q_next = load;
            default:   q_next = q_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) q_reg <= '0;
      else        q_reg <= q_next;
   end

   assign q = q_reg;

endmodule

// File: rtl/shift_register_param.sv
// DEPTH x WIDTH shift register with shift-left/right, parallel load and fill count.
// Defining SHREG_ROTATE_EN adds a rotate input that wraps the end stages instead of inserting in.
module shift_register_param
   import shreg_pkg::*;
#(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 8,
   localparam int CW    = calc_cw(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic [1:0]             mode,
   input  logic [WIDTH-1:0]       in,
   input  logic [DEPTH*WIDTH-1:0] pload,
`ifdef SHREG_ROTATE_EN
   input  logic                   rotate,
`endif
   output logic [DEPTH*WIDTH-1:0] q,
   output logic [WIDTH-1:0]       out_l,
   output logic [WIDTH-1:0]       out_r,
   output logic [CW-1:0]          count,
   output logic                   full
);

   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] stage [DEPTH];
   logic [WIDTH-1:0] shl_entry;
   logic [WIDTH-1:0] shr_entry;
   logic             rot;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;

`ifdef SHREG_ROTATE_EN
   assign rot = rotate;
`else
   assign rot = 1'b0;
`endif

   // Words entering at each end: fresh serial input, or the word falling off the other end.
   assign shl_entry = rot ? stage[DEPTH-1] : in;
   assign shr_entry = rot ? stage[0]       : in;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] lower;
      logic [WIDTH-1:0] upper;

      if (gi == 0) begin : g_lo_end
         assign lower = shl_entry;
      end else begin : g_lo_mid
         assign lower = stage[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_hi_end
         assign upper = shr_entry;
      end else begin : g_hi_mid
         assign upper = stage[gi+1];
      end

      shreg_stage #(.WIDTH(WIDTH)) u_stage (
         .clk   (clk),
         .reset (reset),
         .en    (en),
         .mode  (mode),
         .lower (lower),
         .upper (upper),
         .load  (pload[gi*WIDTH +: WIDTH]),
         .q     (stage[gi])
      );

      assign q[gi*WIDTH +: WIDTH] = stage[gi];
   end

   assign out_l = stage[DEPTH-1];
   assign out_r = stage[0];

   // Count saturates at DEPTH; a rotate moves no new word in, so it leaves the count alone.
   always_comb begin
      count_next = count_reg;
      if (en) begin
         case (mode)
            MODE_LOAD: count_next = DEPTH_CNT;
            MODE_SHL,
            MODE_SHR: begin
               if (!rot && count_reg != DEPTH_CNT) count_next = count_reg + 1'b1;
            end
            default:   count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) count_reg <= '0;
      else        count_reg <= count_next;
   end

   assign count = count_reg;
   assign full  = (count_reg == DEPTH_CNT);

endmodule

// File: tb/tb_shift_register_param.sv
// Directed bench: a WIDTH=1/DEPTH=6 instance and a WIDTH=8/DEPTH=4 instance on one clock.
module tb_shift_register_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Narrow instance
   logic       reset1, en1;
   logic [1:0] mode1;
   logic [0:0] in1;
   logic [5:0] pload1, q1;
   logic [0:0] out_l1, out_r1;
   logic [2:0] count1;
   logic       full1;

   // Wide instance
   logic        reset8, en8;
   logic [1:0]  mode8;
   logic [7:0]  in8;
   logic [31:0] pload8, q8;
   logic [7:0]  out_l8, out_r8;
   logic [2:0]  count8;
   logic        full8;
`ifdef SHREG_ROTATE_EN
   logic rot1 = 1'b0;
   logic rot8;
`endif

   shift_register_param #(.WIDTH(1), .DEPTH(6)) dut1 (
      .clk(clk), .reset(reset1), .en(en1), .mode(mode1), .in(in1), .pload(pload1),
`ifdef SHREG_ROTATE_EN
      .rotate(rot1),
`endif
      .q(q1), .out_l(out_l1), .out_r(out_r1), .count(count1), .full(full1)
   );

   shift_register_param #(.WIDTH(8), .DEPTH(4)) dut8 (
      .clk(clk), .reset(reset8), .en(en8), .mode(mode8), .in(in8), .pload(pload8),
`ifdef SHREG_ROTATE_EN
      .rotate(rot8),
`endif
      .q(q8), .out_l(out_l8), .out_r(out_r8), .count(count8), .full(full8)
   );

   // Inputs change #1 after the edge; outputs are read at that same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset1 = 1'b0; en1 = 1'b1; mode1 = 2'b01; in1 = 1'b1; pload1 = '0;
      reset8 = 1'b0; en8 = 1'b1; mode8 = 2'b11; in8 = 8'hFF; pload8 = 32'hDEADBEEF;
`ifdef SHREG_ROTATE_EN
      rot8 = 1'b0;
`endif
      tick(); tick();
      checks++; if (q1 !== 6'b0) begin failures++; $display("FAIL reset_q1 got=%b exp=%b", q1, 6'b0); end
      checks++; if (count1 !== 3'd0) begin failures++; $display("FAIL reset_count1 got=%0d exp=0", count1); end
      checks++; if (full1 !== 1'b0) begin failures++; $display("FAIL reset_full1 got=%b exp=0", full1); end
      checks++; if (q8 !== 32'h0) begin failures++; $display("FAIL reset_q8 got=%h exp=00000000", q8); end
      checks++; if (count8 !== 3'd0) begin failures++; $display("FAIL reset_count8 got=%0d exp=0", count8); end
      $display("reset: q1=%b count1=%0d q8=%h count8=%0d", q1, count1, q8, count8);
      reset1 = 1'b1; reset8 = 1'b1;
   endtask

   task automatic test_shl_serial();
      logic [5:0] bits;
      bits = 6'b010111;
      en1 = 1'b1; mode1 = 2'b01;
      for (int i = 5; i >= 0; i--) begin
         in1 = bits[i];
         tick();
         $display("shl: in=%b q=%b count=%0d full=%b", bits[i], q1, count1, full1);
         if (i == 3) begin
            checks++; if (count1 !== 3'd3) begin failures++; $display("FAIL shl_count3 got=%0d exp=3", count1); end
            checks++; if (full1 !== 1'b0) begin failures++; $display("FAIL shl_full3 got=%b exp=0", full1); end
         end
      end
      checks++; if (q1 !== 6'b010111) begin failures++; $display("FAIL shl_q got=%b exp=010111", q1); end
      checks++; if (count1 !== 3'd6) begin failures++; $display("FAIL shl_count got=%0d exp=6", count1); end
      checks++; if (full1 !== 1'b1) begin failures++; $display("FAIL shl_full got=%b exp=1", full1); end
      checks++; if (out_l1 !== 1'b0 || out_r1 !== 1'b1) begin failures++; $display("FAIL shl_ends got=%b/%b exp=0/1", out_l1, out_r1); end
      in1 = 1'b0;
      tick();
      $display("shl7: in=0 q=%b count=%0d", q1, count1);
      checks++; if (q1 !== 6'b101110) begin failures++; $display("FAIL shl7_q got=%b exp=101110", q1); end
      checks++; if (count1 !== 3'd6) begin failures++; $display("FAIL shl7_count got=%0d exp=6", count1); end
      mode1 = 2'b00;
   endtask

   task automatic test_load_shr();
      en8 = 1'b1; mode8 = 2'b11; pload8 = 32'h44332211; in8 = 8'hx;
      tick();
      $display("load: q=%h count=%0d out_l=%h out_r=%h", q8, count8, out_l8, out_r8);
      checks++; if (q8 !== 32'h44332211) begin failures++; $display("FAIL load_q got=%h exp=44332211", q8); end
      checks++; if (count8 !== 3'd4) begin failures++; $display("FAIL load_count got=%0d exp=4", count8); end
      checks++; if (full8 !== 1'b1) begin failures++; $display("FAIL load_full got=%b exp=1", full8); end
      checks++; if (out_l8 !== 8'h44) begin failures++; $display("FAIL load_out_l got=%h exp=44", out_l8); end
      checks++; if (out_r8 !== 8'h11) begin failures++; $display("FAIL load_out_r got=%h exp=11", out_r8); end
      mode8 = 2'b10; in8 = 8'hAA; pload8 = 'x;
      tick();
      $display("shr: in=aa q=%h count=%0d", q8, count8);
      checks++; if (q8 !== 32'hAA443322) begin failures++; $display("FAIL shr_q got=%h exp=aa443322", q8); end
      checks++; if (count8 !== 3'd4) begin failures++; $display("FAIL shr_count got=%0d exp=4", count8); end
   endtask

   task automatic test_back_to_back();
      reset8 = 1'b0; tick(); reset8 = 1'b1;
      en8 = 1'b1; pload8 = 'x;
      mode8 = 2'b01; in8 = 8'h01; tick();
      $display("b2b shl: q=%h count=%0d", q8, count8);
      checks++; if (q8 !== 32'h00000001 || count8 !== 3'd1) begin failures++; $display("FAIL b2b_shl got=%h/%0d exp=00000001/1", q8, count8); end
      mode8 = 2'b10; in8 = 8'h02; tick();
      $display("b2b shr: q=%h count=%0d", q8, count8);
      checks++; if (q8 !== 32'h02000000 || count8 !== 3'd2) begin failures++; $display("FAIL b2b_shr got=%h/%0d exp=02000000/2", q8, count8); end
      mode8 = 2'b01; in8 = 8'h03; tick();
      $display("b2b shl: q=%h count=%0d", q8, count8);
      checks++; if (q8 !== 32'h00000003 || count8 !== 3'd3) begin failures++; $display("FAIL b2b_shl2 got=%h/%0d exp=00000003/3", q8, count8); end
      checks++; if (out_l8 !== 8'h00 || out_r8 !== 8'h03) begin failures++; $display("FAIL b2b_ends got=%h/%h exp=00/03", out_l8, out_r8); end
   endtask

   task automatic test_hold();
      reset8 = 1'b0; tick(); reset8 = 1'b1;
      en8 = 1'b1; mode8 = 2'b01; in8 = 8'h5A; tick();
      checks++; if (q8 !== 32'h0000005A || count8 !== 3'd1) begin failures++; $display("FAIL hold_setup got=%h/%0d exp=0000005a/1", q8, count8); end
      en8 = 1'b0; mode8 = 2'b01; in8 = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         $display("en0: q=%h count=%0d", q8, count8);
         checks++; if (q8 !== 32'h0000005A || count8 !== 3'd1) begin failures++; $display("FAIL en0_hold got=%h/%0d exp=0000005a/1", q8, count8); end
      end
      en8 = 1'b1; mode8 = 2'b00; in8 = 'x; pload8 = 'x;
      tick();
      $display("hold: q=%h count=%0d", q8, count8);
      checks++; if (q8 !== 32'h0000005A || count8 !== 3'd1) begin failures++; $display("FAIL mode_hold got=%h/%0d exp=0000005a/1", q8, count8); end
   endtask

   task automatic test_reset_wins();
      en8 = 1'b1; mode8 = 2'b11; pload8 = 32'h44332211; tick();
      reset8 = 1'b0; pload8 = 32'hCAFEF00D; tick();
      $display("reset_wins: q=%h count=%0d full=%b", q8, count8, full8);
      checks++; if (q8 !== 32'h0) begin failures++; $display("FAIL reset_wins_q got=%h exp=00000000", q8); end
      checks++; if (count8 !== 3'd0 || full8 !== 1'b0) begin failures++; $display("FAIL reset_wins_count got=%0d/%b exp=0/0", count8, full8); end
      reset8 = 1'b1;
   endtask

`ifdef SHREG_ROTATE_EN
   task automatic test_rotate();
      en8 = 1'b1; mode8 = 2'b11; pload8 = 32'h44332211; rot8 = 1'b0; tick();
      mode8 = 2'b01; rot8 = 1'b1; in8 = 8'hEE; tick();
      $display("rotl: q=%h count=%0d", q8, count8);
      checks++; if (q8 !== 32'h33221144 || count8 !== 3'd4) begin failures++; $display("FAIL rotl got=%h/%0d exp=33221144/4", q8, count8); end
      mode8 = 2'b10; tick();
      $display("rotr: q=%h count=%0d", q8, count8);
      checks++; if (q8 !== 32'h44332211 || count8 !== 3'd4) begin failures++; $display("FAIL rotr got=%h/%0d exp=44332211/4", q8, count8); end
      reset8 = 1'b0; tick(); reset8 = 1'b1;
      mode8 = 2'b01; rot8 = 1'b0; in8 = 8'h11; tick();
      mode8 = 2'b01; rot8 = 1'b1; in8 = 8'hEE; tick();
      $display("rotl partial: q=%h count=%0d", q8, count8);
      checks++; if (q8 !== 32'h00001100 || count8 !== 3'd1) begin failures++; $display("FAIL rotl_partial got=%h/%0d exp=00001100/1", q8, count8); end
      rot8 = 1'b0; mode8 = 2'b00;
   endtask
`endif

   initial begin
      test_reset();
      test_shl_serial();
      test_load_shr();
      test_back_to_back();
      test_hold();
      test_reset_wins();
`ifdef SHREG_ROTATE_EN
      test_rotate();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
